// File: rtl/sic4_pkg.sv
// Shared types and constants for the SIC-4 control path.
package sic4_pkg;

  localparam int                    SIC4_PC_W     = 8;
  localparam logic [SIC4_PC_W-1:0]  SIC4_RESET_PC = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } sic4_state_t;

endpackage

// File: rtl/sic4_sequencer_if.sv
// Sequencer-facing bundle: imem handshake, decode flags, datapath controls.
interface sic4_sequencer_if #(
  parameter int PC_W = 8
);
  logic            run;
  logic            imem_ack;
  logic            inst_halt;
  logic            inst_branch;
  logic            inst_wb;
  logic            alu_zero;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc;
  logic            imem_req;
  logic            ir_load;
  logic            alu_en;
  logic            reg_we;
  logic            halted;
  logic [2:0]      state;

  modport master (
    input  run, imem_ack, inst_halt, inst_branch, inst_wb, alu_zero, br_target,
    output pc, imem_req, ir_load, alu_en, reg_we, halted, state
  );

  modport slave (
    output run, imem_ack, inst_halt, inst_branch, inst_wb, alu_zero, br_target,
    input  pc, imem_req, ir_load, alu_en, reg_we, halted, state
  );
endinterface

// File: rtl/sic4_pc_unit.sv
// Program counter register; load has priority over increment, wraps modulo 2^PC_W.
module sic4_pc_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/sic4_sequencer.sv
// SIC-4 multi-cycle sequencer: fetch/decode/exec/wb FSM driving the PC unit.
// Fetch stalls while imem_ack is low; ir_load is the only Mealy output.
module sic4_sequencer
  import sic4_pkg::*;
#(
  parameter int              PC_W     = SIC4_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = SIC4_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sic4_sequencer_if.master     bus
);

  sic4_state_t state_q, state_d;
  logic        pc_inc;
  logic        pc_load;
  logic        br_taken;

  assign br_taken = bus.inst_branch && bus.alu_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    bus.ir_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          bus.ir_load = 1'b1;
          state_d     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (bus.inst_halt) begin
          pc_inc  = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_load = br_taken;
        pc_inc  = !br_taken;
        state_d = bus.inst_wb ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (bus.run) state_d = ST_FETCH;
      end
      // Unused encodings recover to IDLE.
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.imem_req = (state_q == ST_FETCH);
  assign bus.alu_en   = (state_q == ST_EXEC);
  assign bus.reg_we   = (state_q == ST_WB);
  assign bus.halted   = (state_q == ST_HALT);
  assign bus.state    = state_q;

  sic4_pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (bus.br_target),
    .pc       (bus.pc)
  );

endmodule

// File: doc/sic4_sequencer.md
# sic4_sequencer

Multi-cycle control sequencer for the SIC-4 core. It owns the 8-bit program counter and steps each instruction through fetch, decode, execute and optional write-back. It stalls fetch on the instruction-memory handshake, resolves conditional branches from the ALU zero flag, and parks the core on a halt instruction until software or the bench re-issues `run`. It sits between instruction memory, the instruction register, the ALU and the register file.

## Interface
- `PC_W`, default 8: program counter width.
- `RESET_PC`, default 0: PC value loaded on reset.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  start from IDLE, or resume from HALT; level-sampled.
- `imem_ack`  in  1  instruction word valid this cycle.
- `inst_halt`  in  1  decoded instruction is HALT.
- `inst_branch`  in  1  decoded instruction is a conditional branch.
- `inst_wb`  in  1  decoded instruction writes the register file.
- `alu_zero`  in  1  ALU result is zero; valid in EXEC.
- `br_target`  in  PC_W  branch destination.
- `pc`  out  PC_W  current program counter (registered).
- `imem_req`  out  1  fetch request.
- `ir_load`  out  1  load instruction register.
- `alu_en`  out  1  ALU operates this cycle.
- `reg_we`  out  1  register-file write enable.
- `halted`  out  1  core is parked in HALT.
- `state`  out  3  current FSM state, for debug.

## Operation
- **FSM states and encodings:** IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- **IDLE:** if `run`=1, go to FETCH. Otherwise stay.
- **FETCH:** `imem_req`=1.
  - `imem_ack`=0: stay in FETCH; `pc` holds.
  - `imem_ack`=1: `ir_load`=1 in the same cycle (Mealy); go to DECODE.
- **DECODE:**
  - `inst_halt`=1: `pc` <= `pc`+1; go to HALT.
  - Otherwise go to EXEC.
- **EXEC:** `alu_en`=1. The PC updates on the exiting edge:
  - If `inst_branch` and `alu_zero`, `pc` <= `br_target`.
  - Otherwise `pc` <= `pc`+1.
  - Next state is WB if `inst_wb`=1, else FETCH.
- **WB:** `reg_we`=1; `pc` does not change; go to FETCH.
- **HALT:** `halted`=1. If `run`=1, go to FETCH, resuming at the instruction after the HALT. `run` is ignored in every other state.
- **PC arithmetic:** modulo 2^PC_W, so 8'hFF+1 = 8'h00. `br_target` is loaded unmodified, including a target equal to the current `pc` (a self-loop).
- **Decode inputs:** `inst_*` are sampled only in DECODE and EXEC and are don't-care elsewhere.
- **Moore outputs:** `imem_req`, `alu_en`, `reg_we` and `halted` are decoded from the state register only.

## Timing
- **Reset:** `rst_n` low forces, immediately and regardless of state, `state`=IDLE and `pc`=RESET_PC. All other outputs are 0 during reset.
- **Reset mid-instruction:** a reset asserted in any state (e.g. WB) aborts the instruction. No `reg_we` pulse is produced after reset asserts.
- **First fetch:** `run` sampled high in IDLE at edge N gives `imem_req`=1 in cycle N+1.
- **Instruction latency with `imem_ack` already high in FETCH:**
  - 3 cycles without write-back: FETCH, DECODE, EXEC.
  - 4 cycles with write-back.
  - Each cycle `imem_ack` is low adds one cycle.
- **PC stability:** `pc` changes only on the EXEC exit edge or the DECODE→HALT edge. It is stable through FETCH, so instruction memory may address directly from `pc`.
- **`run` in HALT:** a one-cycle `run` pulse is sufficient to leave HALT. If `run` is held high, the core leaves HALT on the first edge.

## Structure
- **Shared package `sic4_pkg`:**
  - state enum `sic4_state_t` with the encodings above;
  - `SIC4_PC_W`=8;
  - `SIC4_RESET_PC`=8'h00.
- **Sub-module `sic4_pc_unit`:** the PC register with async reset and inputs `inc`, `load`, `load_val`. `load` has priority over `inc`. The sequencer drives its controls from the state and decode inputs.
- **Size:** roughly 150–250 lines of RTL in total.

## Test plan
- **Reset then run:** `rst_n` low, release, `run`=1 for one cycle, `imem_ack` tied 1, no branch/wb/halt → `pc` steps 0,1,2,3 every 3 cycles; `state` cycles 1,2,3; `reg_we` never asserts.
- **Fetch stall:** `imem_ack` low for 4 cycles in FETCH at `pc`=5 → `imem_req` stays 1, `pc` stays 5, `ir_load` pulses only on the ack cycle.
- **Branch:** at `pc`=10 with `inst_branch`=1, `br_target`=8'h40:
  - `alu_zero`=1 → next fetch at `pc`=8'h40;
  - `alu_zero`=0 → next fetch at `pc`=11.
- **Write-back and wrap:** `inst_wb`=1 at `pc`=8'hFF → exactly one `reg_we` cycle in WB; next fetch at `pc`=8'h00.
- **Halt and resume:** HALT decoded at `pc`=7 → `halted`=1, `pc`=8, `imem_req`=0 for 20 cycles; a single `run` pulse → FETCH at `pc`=8.
- **Reset mid-WB:** `rst_n` asserted during WB → `state`=0, `pc`=RESET_PC and `reg_we`=0 immediately, without waiting for a clock edge.
